// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: steers MEM-stage accesses in 0xFFFF0000-0xFFFF0010 to UART/Ethernet.
// Optional request timeout enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    input  logic        memread,
    output logic        mem_sel,
    output logic        stall,
    output logic [31:0] readdata,
    output logic        bus_err,
    output logic [2:0]  p_addr,
    output logic [31:0] p_wdata,
    output logic        p_we,
    output logic        uart_req,
    input  logic        uart_ack,
    input  logic [31:0] uart_rdata,
    output logic        eth_req,
    input  logic        eth_ack,
    input  logic [31:0] eth_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]  state;
    logic        sel_eth;
    logic        in_mmio;
    logic        hit_uart;
    logic        hit_eth;
    logic        access;
    logic        ack;
    logic        expired;
    logic [31:0] sel_rdata;

    assign in_mmio  = (addr >= 32'hFFFF_0000) && (addr <= 32'hFFFF_0010);
    assign hit_uart = in_mmio && (addr[4:3] == 2'b00);
    assign hit_eth  = in_mmio && (addr[4:3] == 2'b01);
    assign access   = (memread | memwrite) & in_mmio;
    assign mem_sel  = !in_mmio;

    // Only the addressed peripheral's ack is honoured.
    assign ack       = sel_eth ? eth_ack : uart_ack;
    assign sel_rdata = sel_eth ? eth_rdata : uart_rdata;

`ifdef MMIO_TIMEOUT_EN
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    logic [7:0] tcnt;

    assign expired = (tcnt == TLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= 8'd0;
        end else if (state == REQ) begin
            tcnt <= tcnt + 8'd1;
        end else begin
            tcnt <= 8'd0;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel_eth  <= 1'b0;
            p_addr   <= 3'd0;
            p_wdata  <= 32'd0;
            p_we     <= 1'b0;
            readdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        if (hit_uart || hit_eth) begin
                            p_addr  <= addr[2:0];
                            p_wdata <= writedata;
                            p_we    <= memwrite;
                            sel_eth <= hit_eth;
                            state   <= REQ;
                        end else begin
                            readdata <= 32'd0;
                            state    <= ERR;
                        end
                    end
                end
                REQ: begin
                    // An ack in the last allowed cycle beats the timeout.
                    if (ack) begin
                        readdata <= p_we ? 32'd0 : sel_rdata;
                        state    <= DONE;
                    end else if (expired) begin
                        readdata <= 32'd0;
                        state    <= ERR;
                    end
                end
                DONE: state <= IDLE;
                ERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall    = !reset && (((state == IDLE) && access) || (state == REQ));
    assign uart_req = (state == REQ) && !sel_eth;
    assign eth_req  = (state == REQ) && sel_eth;
    assign bus_err  = !reset && (state == ERR);

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed self-checking bench for mmio_bus_ctrl.
// Timeout scenarios are exercised only when MMIO_TIMEOUT_EN is defined.
module tb_mmio_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic        mem_sel;
    logic        stall;
    logic [31:0] readdata;
    logic        bus_err;
    logic [2:0]  p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    logic        uart_req;
    logic        uart_ack = 1'b0;
    logic [31:0] uart_rdata = '0;
    logic        eth_req;
    logic        eth_ack = 1'b0;
    logic [31:0] eth_rdata = '0;

    mmio_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata),
        .memwrite(memwrite), .memread(memread), .mem_sel(mem_sel),
        .stall(stall), .readdata(readdata), .bus_err(bus_err),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we),
        .uart_req(uart_req), .uart_ack(uart_ack), .uart_rdata(uart_rdata),
        .eth_req(eth_req), .eth_ack(eth_ack), .eth_rdata(eth_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Results of the last transaction driven by xact
    int          nst, nur, ner, k;
    logic        err;
    logic [31:0] rdv;
    bit          stab, fin;

    typedef struct {
        logic [31:0] a;
        logic        rd;
        logic        wr;
        logic        exp_sel;
        logic        exp_stall;
    } dvec_t;

    dvec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xact(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input int ackk, input logic [31:0] rdat,
                        input bit stray, input int budget);
        nst = 0; nur = 0; ner = 0; k = 0;
        err = 1'b0; rdv = '0; stab = 1'b1; fin = 1'b0;
        @(negedge clk);
        addr = a; memread = rd; memwrite = wr; writedata = wd;
        for (int c = 0; c < budget && !fin; c++) begin
            #1;
            uart_ack = 1'b0;
            eth_ack  = 1'b0;
            if (uart_req || eth_req) begin
                k++;
                if (p_addr !== a[2:0] || p_we !== wr || p_wdata !== wd) stab = 1'b0;
                if (uart_req) nur++;
                if (eth_req) ner++;
                if (k == ackk) begin
                    if (uart_req) begin uart_ack = 1'b1; uart_rdata = rdat; end
                    else begin eth_ack = 1'b1; eth_rdata = rdat; end
                end
                if (stray && k == 1) begin
                    if (uart_req) begin eth_ack = 1'b1; eth_rdata = 32'hBADBAD00; end
                    else begin uart_ack = 1'b1; uart_rdata = 32'hBADBAD00; end
                end
            end
            if (stall) begin
                nst++;
            end else begin
                rdv = readdata;
                err = bus_err;
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        addr = '0; memread = 1'b0; memwrite = 1'b0;
        uart_ack = 1'b0; eth_ack = 1'b0;
        @(negedge clk);
        #1;
        if (fin) begin
            chk("err_single_pulse", {31'd0, bus_err}, 32'd0);
            chk("idle_no_stall", {31'd0, stall}, 32'd0);
        end
    endtask

    initial begin
        tv[0] = '{32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[1] = '{32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[2] = '{32'hFFFF_0010, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[3] = '{32'hFFFF_0011, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[4] = '{32'hFFFE_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[5] = '{32'hFFFF_0008, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6] = '{32'hFFFF_000F, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[7] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_uart_req", {31'd0, uart_req}, 32'd0);
        chk("rst_eth_req", {31'd0, eth_req}, 32'd0);
        chk("rst_p_addr", {29'd0, p_addr}, 32'd0);
        chk("rst_p_wdata", p_wdata, 32'd0);
        chk("rst_p_we", {31'd0, p_we}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        addr = 32'hFFFF_0000; memread = 1'b1;
        #1;
        chk("rst_stall_forced", {31'd0, stall}, 32'd0);
        addr = '0; memread = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Combinational decode in IDLE; inputs removed before the next edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr = tv[i].a; memread = tv[i].rd; memwrite = tv[i].wr;
            #1;
            chk($sformatf("dec%0d_mem_sel", i), {31'd0, mem_sel}, {31'd0, tv[i].exp_sel});
            chk($sformatf("dec%0d_stall", i), {31'd0, stall}, {31'd0, tv[i].exp_stall});
            #1;
            addr = '0; memread = 1'b0; memwrite = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("dec_no_req", {30'd0, uart_req, eth_req}, 32'd0);

        // UART load, ack in first REQ cycle
        xact(32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 1, 32'hDEADBEEF, 1'b0, 20);
        chk("uld_fin", {31'd0, fin}, 32'd1);
        chk("uld_stall", nst, 2);
        chk("uld_uart_req", nur, 1);
        chk("uld_eth_req", ner, 0);
        chk("uld_stable", {31'd0, stab}, 32'd1);
        chk("uld_rdata", rdv, 32'hDEADBEEF);
        chk("uld_err", {31'd0, err}, 32'd0);

        // Ethernet store, ack in fifth REQ cycle
        xact(32'hFFFF_0008, 1'b0, 1'b1, 32'h12345678, 5, 32'hCAFEF00D, 1'b0, 20);
        chk("est_stall", nst, 6);
        chk("est_eth_req", ner, 5);
        chk("est_uart_req", nur, 0);
        chk("est_stable", {31'd0, stab}, 32'd1);
        chk("est_rdata", rdv, 32'd0);
        chk("est_err", {31'd0, err}, 32'd0);

        // Unmapped address
        xact(32'hFFFF_0010, 1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b0, 20);
        chk("unm_stall", nst, 1);
        chk("unm_req", nur + ner, 0);
        chk("unm_err", {31'd0, err}, 32'd1);
        chk("unm_rdata", rdv, 32'd0);

        // Data memory access
        xact(32'h0000_1000, 1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b0, 20);
        chk("dmem_stall", nst, 0);
        chk("dmem_req", nur + ner, 0);
        chk("dmem_err", {31'd0, err}, 32'd0);

        // Stray eth_ack during UART request
        xact(32'hFFFF_0000, 1'b1, 1'b0, 32'h0, 3, 32'h0BADF00D, 1'b1, 20);
        chk("stray_stall", nst, 4);
        chk("stray_uart_req", nur, 3);
        chk("stray_rdata", rdv, 32'h0BADF00D);

        // Load and store strobes together act as a store
        xact(32'hFFFF_0002, 1'b1, 1'b1, 32'hA5A5_5A5A, 2, 32'h7777_7777, 1'b0, 20);
        chk("rw_stall", nst, 3);
        chk("rw_stable_we", {31'd0, stab}, 32'd1);
        chk("rw_rdata", rdv, 32'd0);

`ifdef MMIO_TIMEOUT_EN
        xact(32'hFFFF_0000, 1'b1, 1'b0, 32'h0, 0, 32'h0, 1'b0, 40);
        chk("to_fin", {31'd0, fin}, 32'd1);
        chk("to_uart_req", nur, 16);
        chk("to_stall", nst, 17);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rdata", rdv, 32'd0);
        xact(32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 16, 32'h1357_9BDF, 1'b0, 40);
        chk("to16_uart_req", nur, 16);
        chk("to16_err", {31'd0, err}, 32'd0);
        chk("to16_rdata", rdv, 32'h1357_9BDF);
`else
        // Without the timeout the request waits indefinitely
        xact(32'hFFFF_0000, 1'b1, 1'b0, 32'h0, 0, 32'h0, 1'b0, 30);
        chk("hang_fin", {31'd0, fin}, 32'd0);
        chk("hang_uart_req", nur, 29);
        chk("hang_still_req", {31'd0, uart_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        // Reset during the third REQ cycle
        @(negedge clk);
        addr = 32'hFFFF_000C; memread = 1'b1;
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            #1;
            if (eth_req) k++;
            if (k == 3) begin
                reset = 1'b1;
                #1;
                chk("mid_rst_stall", {31'd0, stall}, 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        chk("mid_rst_reached", k, 3);
        @(negedge clk);
        #1;
        chk("mid_rst_req", {30'd0, uart_req, eth_req}, 32'd0);
        chk("mid_rst_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b0;
        addr = '0; memread = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_req", {30'd0, uart_req, eth_req}, 32'd0);
        chk("post_rst_err", {31'd0, bus_err}, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);

        // IDLE after reset: a fresh access stalls and issues next cycle
        addr = 32'hFFFF_0008; memread = 1'b1;
        #1;
        chk("post_rst_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("post_rst_eth_req", {31'd0, eth_req}, 32'd1);
        addr = '0; memread = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
# mmio_bus_ctrl

Sequences CPU load/store accesses into the MMIO segment (0xFFFF0000–0xFFFF0010) onto the UART and Ethernet peripherals over a req/ack handshake. While a peripheral transaction is in flight it stalls the pipeline. It returns read data, or flags a bus error for an unmapped address or an unanswered request. It sits beside the MEM stage, in parallel with the data memory, and steers non-MMIO accesses to data memory combinationally.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of REQ cycles without an ack before the access is aborted. Legal range is 2–255. Only used when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- addr  in  32  CPU data address from the MEM stage
- writedata  in  32  CPU store data
- memwrite  in  1  store strobe
- memread  in  1  load strobe
- mem_sel  out  1  1 = the access targets data memory (address outside the MMIO segment); combinational
- stall  out  1  pipeline stall request
- readdata  out  32  MMIO load result, valid while in DONE
- bus_err  out  1  one-cycle error pulse
- p_addr  out  3  addr[2:0] latched at request
- p_wdata  out  32  latched writedata
- p_we  out  1  latched memwrite
- uart_req  out  1  UART request, held until ack
- uart_ack  in  1  UART acknowledge
- uart_rdata  in  32  UART read data, valid with uart_ack
- eth_req  out  1  Ethernet request
- eth_ack  in  1  Ethernet acknowledge
- eth_rdata  in  32  Ethernet read data, valid with eth_ack

## Operation
Address decode (combinational):
- in_mmio = 0xFFFF0000 ≤ addr ≤ 0xFFFF0010, unsigned compare.
- UART window: 0xFFFF0000–0xFFFF0007.
- Ethernet window: 0xFFFF0008–0xFFFF000F.
- 0xFFFF0010 is unmapped.
- mem_sel = !in_mmio.
- access = (memread | memwrite) & in_mmio.

State machine states: IDLE, REQ, DONE, ERR.

IDLE:
- stall = access, combinational.
- If access targets a mapped window: latch p_addr, p_wdata, p_we and the target select; go to REQ.
- If access targets 0xFFFF0010: go to ERR.

REQ:
- stall = 1.
- The selected req is 1; the other req is 0.
- Only the selected peripheral's ack is sampled; an ack from the other peripheral is ignored.
- On ack: capture the selected rdata into readdata (for stores, readdata captures 0), then go to DONE.

DONE:
- stall = 0 and req = 0.
- readdata holds its value; the instruction leaves the MEM stage at the end of this cycle.
- Go to IDLE.

ERR:
- stall = 0, bus_err = 1, readdata = 0, req = 0.
- Go to IDLE.

General rules:
- An ack arriving in IDLE, DONE or ERR is ignored.
- memread and memwrite asserted together are treated as a store (p_we = 1).

## Timing
- Reset values: state = IDLE, uart_req = eth_req = 0, p_addr = 0, p_wdata = 0, p_we = 0, readdata = 0, bus_err = 0. stall is forced to 0 while reset is high.
- Reset asserted mid-transaction: req drops in the cycle after the reset edge and no error is reported.
- Request issue: req rises in the cycle after the access is first seen in IDLE.
- Minimum stall: 2 cycles, when ack arrives in the first REQ cycle. Sequence: IDLE(stall) → REQ(ack) → DONE.
- General stall: 1 + k cycles for an ack in REQ cycle k.
- While req is high, p_addr, p_wdata and p_we are stable.
- Unmapped access: 1 stall cycle, then ERR.

## Configuration
- MMIO_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle.
  - If no ack by the end of REQ cycle TIMEOUT, go to ERR (req drops, bus_err pulses, readdata = 0).
  - An ack in cycle TIMEOUT itself wins over the timeout.
- MMIO_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for ack.

## Test plan
- UART load: load from 0xFFFF0004; uart_ack with rdata 0xDEADBEEF in the first REQ cycle → stall high for 2 cycles, uart_req for 1 cycle, p_addr = 3'b100, readdata = 0xDEADBEEF in DONE, eth_req never rises.
- Ethernet store: store 0x12345678 to 0xFFFF0008; eth_ack delayed 5 cycles → stall high for 6 cycles, p_we = 1, p_wdata stable throughout, DONE follows.
- Unmapped and non-MMIO: load from 0xFFFF0010 → 1 stall cycle, bus_err pulse, readdata = 0. Load from 0x00001000 → mem_sel = 1, stall = 0, no req.
- Timeout (MMIO_TIMEOUT_EN, TIMEOUT = 16): UART load with no ack → uart_req high for 16 cycles, then bus_err. An ack in cycle 16 instead → DONE, no error.
- Reset and stray ack: reset asserted during the 3rd REQ cycle → req low the next cycle, state IDLE, no bus_err. A stray eth_ack during a UART request → ignored.
